// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB register completer.
// Holds the transfer FSM state enum, register address map and PADDR width.
package apb_pkg;

  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_R0  = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_R1  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_R2  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_CNT = 3'd3;

endpackage

// File: rtl/apb_completer.sv
// apb_completer: APB completer with three RW registers and a RO transfer counter.
// Build option APB_COMPLETER_WAIT_EN inserts WAIT wait states per transfer.
module apb_completer
  import apb_pkg::state_t, apb_pkg::IDLE, apb_pkg::READY;
  import apb_pkg::ADDR_W, apb_pkg::ADDR_R0, apb_pkg::ADDR_R1;
  import apb_pkg::ADDR_R2, apb_pkg::ADDR_CNT;
#(
  parameter int m    = 8,
  parameter int WAIT = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [m-1:0]      PWDATA,
  output logic [m-1:0]      PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [m-1:0]      o_reg0
);

  localparam logic [3:0] WAIT_CFG = 4'(WAIT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [m-1:0]      r_wdata;
  logic [m-1:0]      r_rdata;
  logic              r_err;
  logic [m-1:0]      r_reg [3];
  logic [m-1:0]      r_cnt;
  logic [m-1:0]      w_rd;
  logic              w_err;
  logic              w_setup;
  logic              w_commit;

`ifdef APB_COMPLETER_WAIT_EN
  logic [3:0]        r_wcnt;
  logic [3:0]        w_wcnt_nxt;
`else
  logic [3:0]        w_unused_wait;
  assign w_unused_wait = WAIT_CFG;
`endif

  assign w_setup  = (r_state == IDLE) && PSEL && !PENABLE;
  assign w_commit = (r_state == READY) && PSEL && PENABLE;

  assign PREADY  = (r_state == READY);
  assign PSLVERR = PREADY ? r_err : 1'b0;
  assign PRDATA  = (PREADY && !r_write) ? r_rdata : '0;
  assign o_reg0  = r_reg[0];

  // read-data mux and error decode, sampled at capture
  always_comb begin
    w_rd = '0;
    unique case (PADDR)
      ADDR_R0:  w_rd = r_reg[0];
      ADDR_R1:  w_rd = r_reg[1];
      ADDR_R2:  w_rd = r_reg[2];
      ADDR_CNT: w_rd = r_cnt;
      default:  w_rd = '0;
    endcase
    w_err = PWRITE ? (PADDR >= ADDR_CNT) : (PADDR > ADDR_CNT);
  end

  // FSM state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

`ifdef APB_COMPLETER_WAIT_EN
  // wait-state down-counter
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_wcnt <= '0;
    else        r_wcnt <= w_wcnt_nxt;
  end
`endif

  // next-state logic: setup capture, wait countdown, commit or abort
  always_comb begin
    w_state_nxt = r_state;
`ifdef APB_COMPLETER_WAIT_EN
    w_wcnt_nxt  = r_wcnt;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_setup) begin
`ifdef APB_COMPLETER_WAIT_EN
          w_wcnt_nxt  = WAIT_CFG;
          w_state_nxt = (WAIT_CFG != 4'd0) ? apb_pkg::WAIT : READY;
`else
          w_state_nxt = READY;
`endif
        end
      end
`ifdef APB_COMPLETER_WAIT_EN
      apb_pkg::WAIT: begin
        if (!PSEL) begin
          w_state_nxt = IDLE;
          w_wcnt_nxt  = '0;
        end else if (PENABLE) begin
          w_wcnt_nxt = r_wcnt - 4'd1;
          if (r_wcnt == 4'd1) w_state_nxt = READY;
        end
      end
`endif
      READY: begin
        if (!PSEL || PENABLE) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // capture, register commit and transfer counter
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_reg[0] <= '0;
      r_reg[1] <= '0;
      r_reg[2] <= '0;
    end else begin
      if (w_setup) begin
        r_addr  <= PADDR;
        r_write <= PWRITE;
        r_wdata <= PWDATA;
        r_rdata <= PWRITE ? '0 : w_rd;
        r_err   <= w_err;
      end
      if (w_commit) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_write && (r_addr < ADDR_CNT))
          r_reg[r_addr[1:0]] <= r_wdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_completer.sv
// tb_apb_completer: directed scoreboard bench for apb_completer.
// Works with APB_COMPLETER_WAIT_EN defined (2 waits) or undefined (0 waits).
module tb_apb_completer;

`ifdef APB_COMPLETER_WAIT_EN
  localparam int EXPW = 2;
`else
  localparam int EXPW = 0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } resp_t;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [2:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;
  logic [7:0] o_reg0;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  resp_t      sb_q[$];
  logic [7:0] mr [3];
  logic [7:0] exp_cnt;

  apb_completer #(.m(8), .WAIT(2)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .o_reg0  (o_reg0)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mr[0] = 8'h00;
    mr[1] = 8'h00;
    mr[2] = 8'h00;
    exp_cnt = 8'h00;
    sb_q.delete();
  endtask

  // One transfer; called #1 after a rising edge, returns #1 after completion.
  task automatic xfer(input logic wr, input logic [2:0] a, input logic [7:0] d);
    resp_t e;
    resp_t got;
    int waits;
    e.err  = wr ? (a >= 3'd3) : (a >= 3'd4);
    e.data = 8'h00;
    if (!wr) begin
      if (a < 3'd3)       e.data = mr[a[1:0]];
      else if (a == 3'd3) e.data = exp_cnt;
    end
    sb_q.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    while (!PREADY && waits <= 20) begin
      waits++;
      @(posedge PCLK); #1;
    end
    chk("wait_cycles", waits, EXPW);
    if (PREADY) begin
      got = sb_q.pop_front();
      chk("prdata", PRDATA, got.data);
      chk("pslverr", PSLVERR, got.err);
      @(posedge PCLK); #1;
      if (wr && a < 3'd3) mr[a[1:0]] = d;
      exp_cnt = exp_cnt + 8'd1;
    end else begin
      void'(sb_q.pop_front());
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    PWRITE = 1'b0; PADDR = 3'd0; PWDATA = 8'h00;
    model_reset();
    #12;
    chk("rst_pready", PREADY, 1'b0);
    chk("rst_prdata", PRDATA, 8'h00);
    chk("rst_pslverr", PSLVERR, 1'b0);
    chk("rst_reg0", o_reg0, 8'h00);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    // write then read R0, then counter
    xfer(1'b1, 3'd0, 8'hF3);
    chk("reg0_after_wr", o_reg0, 8'hF3);
    xfer(1'b0, 3'd0, 8'h00);
    xfer(1'b0, 3'd3, 8'h00);

    // R1 round trip
    xfer(1'b1, 3'd1, 8'hA5);
    xfer(1'b0, 3'd1, 8'h00);

    // error transfers: write to CNT, read unmapped
    xfer(1'b1, 3'd3, 8'h77);
    xfer(1'b0, 3'd6, 8'h00);
    xfer(1'b0, 3'd3, 8'h00);

    // PENABLE without setup is ignored
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 3'd2; PWDATA = 8'h99;
    @(posedge PCLK); #1;
    chk("stray_enable_pready", PREADY, 1'b0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;

    // abort: write 0x11 to R2, PSEL dropped before completion
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 3'd2; PWDATA = 8'h11;
    @(posedge PCLK); #1;
`ifdef APB_COMPLETER_WAIT_EN
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    chk("abort_in_wait", PREADY, 1'b0);
`endif
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    chk("abort_idle_pready", PREADY, 1'b0);
    xfer(1'b0, 3'd2, 8'h00);
    xfer(1'b0, 3'd3, 8'h00);
    xfer(1'b0, 3'd0, 8'h00);

    // asynchronous reset in the middle of a transfer
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 3'd0; PWDATA = 8'h55;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    PRESET = 1'b1;
    #1;
    chk("mid_rst_pready", PREADY, 1'b0);
    chk("mid_rst_prdata", PRDATA, 8'h00);
    chk("mid_rst_reg0", o_reg0, 8'h00);
    PSEL = 1'b0; PENABLE = 1'b0;
    model_reset();
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    xfer(1'b0, 3'd3, 8'h00);

    // counter wrap: 256 completed transfers from reset
    for (int i = 1; i < 256; i++) xfer(1'b1, 3'd2, 8'(i));
    chk("model_cnt_wrapped", exp_cnt, 8'h00);
    xfer(1'b0, 3'd3, 8'h00);
    xfer(1'b0, 3'd3, 8'h00);
    xfer(1'b0, 3'd2, 8'h00);

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_completer.md
APB_COMPLETER -- requirements
Module: apb_completer

Interface
REQ-001 Parameter: m, 8, data width of PWDATA, PRDATA and all registers.
REQ-002 Parameter: WAIT, 2, wait states per transfer when APB_COMPLETER_WAIT_EN is defined (legal 0..15).
REQ-003 PCLK  in  1  single clock; all state on rising edge.
REQ-004 PRESET  in  1  reset, asynchronous, active-high.
REQ-005 PSEL  in  1  completer selected.
REQ-006 PENABLE  in  1  access phase indicator.
REQ-007 PWRITE  in  1  1=write, 0=read.
REQ-008 PADDR  in  3  register address.
REQ-009 PWDATA  in  m  write data.
REQ-010 PRDATA  out  m  read data, valid while PREADY=1 on a read.
REQ-011 PREADY  out  1  transfer completes on the edge where PSEL&PENABLE&PREADY.
REQ-012 PSLVERR  out  1  error response, valid only while PREADY=1.
REQ-013 o_reg0  out  m  current value of register 0, to downstream logic.

Function
REQ-014 Register map: addr 0..2 = RW registers R0..R2; addr 3 = RO transfer counter CNT; addr 4..7 = unmapped.
REQ-015 FSM states IDLE, WAIT, READY; PREADY=1 only in READY.
REQ-016 IDLE: on PSEL=1 & PENABLE=0, capture PADDR, PWRITE, PWDATA; go WAIT if the effective wait count is >0, else READY.
REQ-017 WAIT: counter loaded with WAIT at capture, decremented each cycle with PSEL&PENABLE; go READY on the edge where it reaches 0.
REQ-018 READY: with PSEL&PENABLE, commit the transfer on that edge and return to IDLE.
REQ-019 Zero-wait latency: setup at edge N, PREADY=1 during the cycle after edge N, completion at edge N+1.
REQ-020 Write commit: R[addr] <= captured PWDATA for addr 0..2; PSLVERR=0.
REQ-021 Write to addr 3 or 4..7: no state change; PSLVERR=1.
REQ-022 Read: PRDATA = R[addr] or CNT, registered at capture so it is stable through WAIT and READY; addr 4..7 gives PRDATA=0 and PSLVERR=1.
REQ-023 CNT increments by 1 on every completed transfer, including error transfers; wraps 2^m-1 -> 0.
REQ-024 PSEL=0 in WAIT or READY: abort to IDLE with no commit and no CNT increment.
REQ-025 PENABLE=1 seen in IDLE without a preceding setup: ignored; stay IDLE.
REQ-026 Back-to-back: a setup phase on the cycle after completion is captured normally from IDLE.
REQ-027 PRDATA=0 and PSLVERR=0 whenever PREADY=0.

Reset
REQ-028 PRESET=1 asynchronously forces state IDLE, R0..R2=0, CNT=0, wait counter 0, PREADY=0, PSLVERR=0, PRDATA=0, o_reg0=0.
REQ-029 Reset mid-transfer discards the transfer; the first transfer after release starts from IDLE.

Configuration
REQ-030 Macro APB_COMPLETER_WAIT_EN: when defined, WAIT wait states are inserted per REQ-017.
REQ-031 When APB_COMPLETER_WAIT_EN is undefined, the effective wait count is 0; WAIT state and counter are not built; every transfer is zero-wait.

Structure
REQ-032 Package apb_pkg holds: the state enum (IDLE, WAIT, READY), address constants ADDR_R0..ADDR_CNT, and PADDR width 3.
REQ-033 Single module; no sub-module.

Verification (m=8, WAIT=2 with macro unless noted)
REQ-034 Reset: PRESET=1 mid-WAIT -> PREADY=0, PRDATA=0, o_reg0=0, state IDLE immediately, before the next edge.
REQ-035 Write 0xF3 to addr 0, then read addr 0 -> PREADY low 2 cycles, then high; o_reg0=0xF3; PRDATA=0xF3; CNT=2.
REQ-036 Macro undefined: write 0xA5 to addr 1 -> PREADY=1 in the first access cycle; read-back 0xA5 with zero wait.
REQ-037 Write to addr 3 and read addr 6 -> PSLVERR=1 on both; PRDATA=0 on the read; CNT unchanged by the write value, incremented by 2.
REQ-038 PSEL dropped in WAIT during a write of 0x11 to addr 2 -> R2 unchanged, CNT unchanged; next setup accepted.
REQ-039 256 completed transfers from reset -> reading addr 3 returns 0x00 (wrap), then 0x01 on the following read.
